// File: rtl/reg_dump_pkg.sv
// Shared types and default widths for the register-dump reader.
package reg_dump_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SEND,
    CSUM,
    DONE
  } state_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [ADDR_W_DEF-1:0] idx;
    logic                  last;
  } word_t;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Valid/ready output stream of the register-dump reader; master = reader, slave = debug sink.
interface reg_dump_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_idx;
  logic              out_last;

  modport master (output out_valid, out_data, out_idx, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_idx, out_last, output out_ready);
endinterface

// File: rtl/reg_dump_reader.sv
// Walks the bank read port from FIRST_REG to LAST_REG and streams each captured word out.
// Build option REG_DUMP_CHECKSUM_EN appends a trailing XOR-of-all-words beat.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] rd,
  reg_dump_reader_if.master dump,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_idx_q, out_idx_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  // The bank is only addressed while capturing; it idles at register 0.
  assign ra = (state_q == READ) ? idx_q : '0;

  assign dump.out_valid = out_valid_q;
  assign dump.out_data  = out_data_q;
  assign dump.out_idx   = out_idx_q;
  assign dump.out_last  = out_last_q;
  assign busy           = busy_q;
  assign done           = done_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          idx_d   = FIRST_IDX;
          busy_d  = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      READ: begin
        out_data_d  = rd;
        out_idx_d   = idx_q;
        out_valid_d = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
        csum_d      = csum_q ^ rd;
`else
        out_last_d  = (idx_q == LAST_IDX);
`endif
        state_d     = SEND;
      end
      SEND: begin
        if (dump.out_ready) begin
          if (idx_q != LAST_IDX) begin
            idx_d       = idx_q + 1'b1;
            out_valid_d = 1'b0;
            state_d     = READ;
          end else begin
`ifdef REG_DUMP_CHECKSUM_EN
            // Checksum beat follows directly; csum_q already holds the last word.
            out_data_d  = csum_q;
            out_idx_d   = '0;
            out_last_d  = 1'b1;
            out_valid_d = 1'b1;
            state_d     = CSUM;
`else
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = DONE;
`endif
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      CSUM: begin
        if (dump.out_ready) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = DONE;
        end
      end
`endif
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= FIRST_IDX;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: table-driven dumps, hand-written corner cases and
// randomized dumps compared against an expected-word list built from the bank contents.
module tb_reg_dump_reader;
  import reg_dump_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, start2;
  logic [AW-1:0] ra, ra2;
  logic [DW-1:0] rd, rd2;
  logic          busy, done, busy2, done2;
  logic [DW-1:0] bank [16];

  int n_tests = 0;
  int n_fail  = 0;
  int ndone;
  word_t exp_q[$];
  word_t got_q[$];

  reg_dump_reader_if #(.DATA_W(DW), .ADDR_W(AW)) dif ();
  reg_dump_reader_if #(.DATA_W(DW), .ADDR_W(AW)) dif2 ();

  assign rd  = bank[ra];
  assign rd2 = bank[ra2];

  always #5 clk = ~clk;

  reg_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .FIRST_REG(0), .LAST_REG(15)) dut (
    .clk(clk), .rst(rst), .start(start), .ra(ra), .rd(rd), .dump(dif),
    .busy(busy), .done(done)
  );

  reg_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .FIRST_REG(15), .LAST_REG(15)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .ra(ra2), .rd(rd2), .dump(dif2),
    .busy(busy2), .done(done2)
  );

  typedef struct {
    logic [31:0] base;
    int          stall_idx;
    int          stall_n;
    int          exp_cyc;
  } vec_t;
  vec_t tbl[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] base);
    for (int i = 0; i < 16; i++) bank[i] = base + 32'(i);
  endtask

  // Reference: every register FIRST..LAST in order, last flag on the final one,
  // plus an XOR trailer word when the checksum option is built in.
  task automatic build_expected();
    logic [DW-1:0] x;
    word_t w;
    x = '0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      w.data = bank[i];
      w.idx  = AW'(i);
      w.last = (i == 15) && (CS == 0);
      exp_q.push_back(w);
      x = x ^ bank[i];
    end
    if (CS != 0) begin
      w.data = x;
      w.idx  = '0;
      w.last = 1'b1;
      exp_q.push_back(w);
    end
  endtask

  task automatic run_dump(input int stall_idx, input int stall_n, input int start_idx,
                          input int wr_idx, input int wr_addr, input logic [31:0] wr_data,
                          input bit rand_ready, output int done_at);
    int    cyc, stall_left, last_hs;
    bit    holding, wr_done, st_done;
    word_t hold, cur;
    got_q.delete();
    done_at = -1; ndone = 0; stall_left = stall_n; last_hs = 0;
    holding = 1'b0; wr_done = 1'b0; st_done = 1'b0; hold = '0;
    @(negedge clk); start = 1'b1; dif.out_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1));
    cyc = 0;
    while (1) begin
      cur.data = dif.out_data;
      cur.idx  = dif.out_idx;
      cur.last = dif.out_last;
      start = 1'b0;
      if (done_at >= 0 && cyc > done_at) begin
        check("idle_after_done", {busy, done, dif.out_valid}, 3'b000);
        break;
      end
      if (cyc > 600) begin
        check("dump_timeout", 64'(cyc), 64'(0));
        break;
      end
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = cyc;
      end
      if (dif.out_valid) begin
        if (holding) check("hold_stable", 64'(cur), 64'(hold));
        else begin
          holding = 1'b1;
          hold = cur;
          if (!rand_ready && got_q.size() == 0) check("first_word_lat", 64'(cyc), 64'(1));
          if (!rand_ready && got_q.size() > 0 && got_q.size() < 16)
            check("word_gap", 64'(cyc - last_hs), 64'(2));
        end
        if (!wr_done && wr_idx >= 0 && int'(cur.idx) == wr_idx) begin
          bank[wr_addr] = wr_data;
          wr_done = 1'b1;
        end
        if (!st_done && start_idx >= 0 && int'(cur.idx) == start_idx) begin
          start = 1'b1;
          st_done = 1'b1;
        end
        if (stall_left > 0 && int'(cur.idx) == stall_idx) begin
          dif.out_ready = 1'b0;
          stall_left--;
        end else begin
          dif.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (dif.out_ready) begin
          got_q.push_back(cur);
          holding = 1'b0;
          last_hs = cyc;
        end
      end else begin
        dif.out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
    end
    dif.out_ready = 1'b0;
    start = 1'b0;
  endtask

  task automatic compare_words(input string tag);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_word%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    check({tag, "_done_pulses"}, 64'(ndone), 64'(1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_at, cnt, guard;
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    dif.out_ready = 1'b0; dif2.out_ready = 1'b0;
    preload(32'h100);
    repeat (2) @(negedge clk);
    check("reset_state", {dif.out_valid, dif.out_data, dif.out_idx, dif.out_last, busy, done, ra},
          '0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ra", {ra, busy}, '0);

    // Async reset while a word is waiting for the sink.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    guard = 0;
    while (!dif.out_valid && guard < 10) begin @(negedge clk); guard++; end
    check("reset_reached_send", 64'(dif.out_valid), 64'(1));
    #2 rst = 1'b1;
    #1 check("reset_midsend", {dif.out_valid, dif.out_data, dif.out_idx, dif.out_last, busy, done, ra},
             '0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("after_reset_idle", {busy, dif.out_valid, done, ra}, '0);

    tbl[0] = '{32'h0000_0100, -1, 0, 33 + CS};
    tbl[1] = '{32'h0000_0100,  3, 5, 38 + CS};
    tbl[2] = '{32'hDEAD_0000,  0, 2, 35 + CS};
    tbl[3] = '{32'hFFFF_FFF0, 15, 3, 36 + CS};
    for (int t = 0; t < 4; t++) begin
      preload(tbl[t].base);
      build_expected();
      run_dump(tbl[t].stall_idx, tbl[t].stall_n, -1, -1, 0, '0, 1'b0, done_at);
      compare_words($sformatf("tbl%0d", t));
      check($sformatf("tbl%0d_cycles", t), 64'(done_at + 1), 64'(tbl[t].exp_cyc));
    end

    // Bank write while idx 2 is being sent lands before R5 is read.
    preload(32'h100);
    build_expected();
    exp_q[5].data = 32'hFF;
    if (CS != 0) exp_q[16].data = exp_q[16].data ^ 32'h105 ^ 32'hFF;
    run_dump(-1, 0, -1, 2, 5, 32'hFF, 1'b0, done_at);
    compare_words("conc_write");

    // start pulsed mid-dump is ignored.
    preload(32'h100);
    build_expected();
    run_dump(-1, 0, 7, -1, 0, '0, 1'b0, done_at);
    compare_words("start_busy");
    check("start_busy_cycles", 64'(done_at + 1), 64'(33 + CS));

    // Checksum reflects a changed R0.
    preload(32'h100);
    bank[0] = 32'h1FF;
    build_expected();
    run_dump(-1, 0, -1, -1, 0, '0, 1'b0, done_at);
    compare_words("csum_r0");

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) bank[i] = $urandom;
      build_expected();
      run_dump(-1, 0, -1, -1, 0, '0, 1'b1, done_at);
      compare_words($sformatf("rand%0d", r));
    end

    // Single-register range on the second instance.
    preload(32'hA500);
    @(negedge clk); start2 = 1'b1; dif2.out_ready = 1'b1;
    @(negedge clk); start2 = 1'b0;
    cnt = 0;
    guard = 0;
    while (!done2 && guard < 50) begin
      if (dif2.out_valid) begin
        if (cnt == 0)
          check("single_word", {dif2.out_data, dif2.out_idx, dif2.out_last},
                {bank[15], 4'd15, (CS == 0)});
        else
          check("single_csum", {dif2.out_data, dif2.out_idx, dif2.out_last},
                {bank[15], 4'd0, 1'b1});
        cnt++;
      end
      @(negedge clk);
      guard++;
    end
    check("single_done_seen", 64'(done2), 64'(1));
    check("single_count", 64'(cnt), 64'(1 + CS));
    dif2.out_ready = 1'b0;
    @(negedge clk);
    check("single_idle", {busy2, done2}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Read-side sequencer for the processor register bank.
- On a start pulse it walks one bank read port over a register range and captures each value.
- It streams the captured values out over a valid/ready handshake to a debug sink, such as a VGA text overlay or a UART bridge.
- It drives the read address port and consumes read data; it never writes the bank.

Parameters:
- DATA_W, 32, register word width.
- ADDR_W, 4, register address width (16 registers).
- FIRST_REG, 0, first register index dumped.
- LAST_REG, 15, last register index dumped; FIRST_REG <= LAST_REG <= 2**ADDR_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin dump; sampled only in IDLE.
- ra  out  ADDR_W  register bank read address.
- rd  in  DATA_W  register bank read data; combinational from ra, valid in the same cycle.
- out_valid  out  1  out_data/out_idx/out_last valid.
- out_ready  in  1  sink accepts the word.
- out_data  out  DATA_W  captured register value.
- out_idx  out  ADDR_W  index of the captured register.
- out_last  out  1  final word of the dump.
- busy  out  1  dump in progress (any state but IDLE).
- done  out  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset (async, immediate): state=IDLE; idx=FIRST_REG; ra=0; out_valid=0; out_data=0; out_idx=0; out_last=0; busy=0; done=0.
- Reset mid-dump aborts at once; out_valid drops without a handshake.
- FSM states: IDLE, READ, SEND, DONE (plus CSUM under the optional feature).
- IDLE: ra=0.
  - start=1 -> READ, idx=FIRST_REG.
- READ: ra=idx combinationally.
  - On the next edge: out_data<=rd, out_idx<=idx, out_valid<=1, out_last<=(idx==LAST_REG and feature off) -> SEND.
- SEND: out_valid, out_data, out_idx and out_last held stable until out_valid&out_ready.
  - On handshake with idx!=LAST_REG: idx++, out_valid<=0 -> READ.
  - On handshake with idx==LAST_REG: out_valid<=0 -> DONE (or CSUM).
- DONE: done=1 for exactly one cycle -> IDLE; busy deasserts on entry to IDLE.
- Throughput is 2 cycles per word with out_ready held high.
  - A full 16-register dump, from start to the done pulse, takes 33 cycles.
- Registers are not frozen. Each word reflects the bank contents in its own READ cycle, so a bank write during a dump is visible if it precedes that register's READ.
- start while busy is ignored. A start held high during DONE does not restart; restart requires start seen in IDLE.
- out_ready is ignored when out_valid=0.
- idx never wraps; LAST_REG terminates the dump.

Optional Feature:
- Macro: REG_DUMP_CHECKSUM_EN.
- Defined:
  - A running XOR of all dumped words is kept, cleared on start.
  - After the LAST_REG handshake, the FSM enters CSUM and presents out_data=XOR, out_idx=0, out_last=1, out_valid=1 until handshake, then goes to DONE.
  - out_last is 0 on register words.
- Undefined: there is no CSUM state, no XOR register, and out_last accompanies the LAST_REG word.

Decomposition:
- Shared package reg_dump_pkg holds:
  - the state enum typedef (IDLE, READ, SEND, CSUM, DONE);
  - DATA_W/ADDR_W default constants;
  - a word struct {data, idx, last}.
- No sub-module; the FSM, index counter and output register fit in one module.

Test Plan:
- Reset: assert rst mid-SEND with out_valid=1 -> all outputs 0 in the same cycle; after release, state is IDLE and busy=0.
- Full dump: bank preloaded with Rn=32'h100+n, out_ready=1, pulse start:
  - 16 words received in order, idx 0..15, data 0x100..0x10F;
  - out_last only with idx 15;
  - done pulses 33 cycles after start.
- Backpressure: hold out_ready=0 for 5 cycles on idx 3 -> out_data=0x103 and out_idx=3 stay stable; idx 4 appears 2 cycles after release.
- Concurrent write: while idx 2 is in SEND, write R5=32'hFF via the bank write port -> word idx 5 reads 0xFF.
- Start while busy and range: pulse start at idx 7 -> no restart, total still 16 words; with FIRST_REG=LAST_REG=15, exactly one word, out_last=1.
- With REG_DUMP_CHECKSUM_EN and the same preload: a 17th word carries data=XOR(0x100..0x10F)=0x000, idx=0, last=1; change R0 to 0x1FF -> checksum=0x0FF.
